// File: rtl/key_event_encoder.sv
// Multi-channel push-button front end: sync, debounce, press/auto-repeat detect,
// and serialisation of all pending events into a one-cycle key code stream.
module key_event_encoder #(
    parameter int unsigned N_KEYS        = 3,
    parameter int unsigned CODE_W        = 2,
    parameter int unsigned DB_CYCLES     = 2_000_000,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] btn,
    output logic [CODE_W-1:0] key_code,
    output logic              key_repeat,
    output logic [N_KEYS-1:0] key_level
);

    localparam int unsigned DB_W        = $clog2(DB_CYCLES + 1);
    localparam int unsigned DB_LAST     = (DB_CYCLES > 0) ? DB_CYCLES - 1 : 0;
    localparam bit          REP_EN      = (REPEAT_DELAY > 0);
    localparam int unsigned HOLD_MAX0   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_MAX    = (HOLD_MAX0 > 0) ? HOLD_MAX0 : 1;
    localparam int unsigned HOLD_W      = $clog2(HOLD_MAX + 1);
    localparam int unsigned DELAY_LAST  = REP_EN ? REPEAT_DELAY - 1 : 0;
    localparam int unsigned PERIOD_LAST = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [DB_W-1:0]   r_db_cnt   [N_KEYS];
    logic [HOLD_W-1:0] r_hold_cnt [N_KEYS];
    logic [N_KEYS-1:0] r_hold_first;
    logic [N_KEYS-1:0] r_pend;
    logic [N_KEYS-1:0] r_rep_flag;

    logic [DB_W-1:0]   w_db_cnt_nxt   [N_KEYS];
    logic [HOLD_W-1:0] w_hold_cnt_nxt [N_KEYS];
    logic [N_KEYS-1:0] w_hold_first_nxt;
    logic [N_KEYS-1:0] w_lvl_nxt;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_rep_hit;
    logic [N_KEYS-1:0] w_grant;
    logic [N_KEYS-1:0] w_pend_nxt;
    logic [N_KEYS-1:0] w_rep_nxt;
    logic [CODE_W-1:0] w_win;
    logic              w_any;

    // Per-channel debounce and hold-to-repeat timing
    always_comb begin
        w_lvl_nxt        = key_level;
        w_press          = '0;
        w_rep_hit        = '0;
        w_hold_first_nxt = r_hold_first;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            w_db_cnt_nxt[i]   = '0;
            w_hold_cnt_nxt[i] = '0;
            if (r_s2[i] != key_level[i]) begin
                if (r_db_cnt[i] == DB_W'(DB_LAST)) begin
                    w_lvl_nxt[i] = ~key_level[i];
                end else begin
                    w_db_cnt_nxt[i] = r_db_cnt[i] + DB_W'(1);
                end
            end
            w_press[i] = w_lvl_nxt[i] & ~key_level[i];
            // Count only while held both before and after this edge, so the
            // press edge and the release edge both restart the delay phase.
            if (REP_EN && w_lvl_nxt[i] && key_level[i]) begin
                if (r_hold_cnt[i] == (r_hold_first[i] ? HOLD_W'(DELAY_LAST) : HOLD_W'(PERIOD_LAST))) begin
                    w_rep_hit[i]        = 1'b1;
                    w_hold_first_nxt[i] = 1'b0;
                end else begin
                    w_hold_cnt_nxt[i] = r_hold_cnt[i] + HOLD_W'(1);
                end
            end else begin
                w_hold_first_nxt[i] = 1'b1;
            end
        end
    end

    // Highest pending index wins; set beats clear on the same edge
    always_comb begin
        w_any   = 1'b0;
        w_win   = '0;
        w_grant = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                w_win = CODE_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            w_grant[i] = w_any && (w_win == CODE_W'(i));
        end
        w_pend_nxt = (r_pend & ~w_grant) | w_press | w_rep_hit;
        w_rep_nxt  = r_rep_flag;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (w_press[i]) begin
                w_rep_nxt[i] = 1'b0;
            end else if (w_rep_hit[i] && !(r_pend[i] && !w_grant[i] && !r_rep_flag[i])) begin
                w_rep_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_hold_first <= '1;
            r_pend       <= '0;
            r_rep_flag   <= '0;
            key_level    <= '0;
            key_code     <= '0;
            key_repeat   <= 1'b0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                r_db_cnt[i]   <= '0;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            r_s1         <= btn;
            r_s2         <= r_s1;
            r_hold_first <= w_hold_first_nxt;
            r_pend       <= w_pend_nxt;
            r_rep_flag   <= w_rep_nxt;
            key_level    <= w_lvl_nxt;
            key_code     <= w_any ? (w_win + CODE_W'(1)) : '0;
            key_repeat   <= w_any ? r_rep_flag[w_win] : 1'b0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                r_db_cnt[i]   <= w_db_cnt_nxt[i];
                r_hold_cnt[i] <= w_hold_cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder; expected events are queued at stimulus
// time with their emission cycle and matched by a negedge monitor.
module tb_key_event_encoder;

    localparam int unsigned N_KEYS = 3;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned DB     = 4;
    localparam int unsigned RDLY   = 20;
    localparam int unsigned RPER   = 8;
    localparam int          LAT    = DB + 3;

    typedef struct {
        int code;
        int rep;
        int cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_KEYS-1:0] btn;
    logic [CODE_W-1:0] key_code;
    logic              key_repeat;
    logic [N_KEYS-1:0] key_level;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    ev_t q[$];

    key_event_encoder #(
        .N_KEYS(N_KEYS), .CODE_W(CODE_W), .DB_CYCLES(DB),
        .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .key_code(key_code), .key_repeat(key_repeat), .key_level(key_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int code, input int rep, input int at);
        ev_t e;
        e.code = code;
        e.rep  = rep;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: each emitted code must match the queue head at its cycle
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event", 32'(cyc), 32'(q[0].cyc));
                void'(q.pop_front());
            end
            if (key_code !== '0) begin
                if (q.size() == 0) begin
                    check("unexpected_event", 32'(key_code), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("event_code",   32'(key_code),   32'(e.code));
                    check("event_repeat", 32'(key_repeat), 32'(e.rep));
                    check("event_cycle",  32'(cyc),        32'(e.cyc));
                end
            end else begin
                check("idle_repeat", 32'(key_repeat), 32'd0);
            end
        end
    end

    initial begin
        int c;
        rst = 1'b0;
        btn = '0;

        // Reset held three cycles
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("rst_code",  32'(key_code),   32'd0);
            check("rst_rep",   32'(key_repeat), 32'd0);
            check("rst_level", 32'(key_level),  32'd0);
        end
        rst    = 1'b1;
        mon_en = 1'b1;
        step(2);
        check("post_rst_level", 32'(key_level), 32'd0);

        // Clean press on channel 2
        c = cyc;
        btn = 3'b100;
        push(3, 0, c + LAT);
        step(12);
        check("press2_level", 32'(key_level), 32'b100);
        btn = 3'b000;
        step(12);
        check("release2_level", 32'(key_level), 32'd0);

        // Bounce on channel 0: never stable for DB samples
        for (int k = 0; k < 10; k++) begin
            btn[0] = ~btn[0];
            step(2);
            check("bounce_level", 32'(key_level[0]), 32'd0);
        end
        btn = 3'b000;
        step(10);
        check("bounce_final_level", 32'(key_level), 32'd0);

        // Simultaneous press on all channels, released before any repeat
        c = cyc;
        btn = 3'b111;
        push(3, 0, c + LAT);
        push(2, 0, c + LAT + 1);
        push(1, 0, c + LAT + 2);
        step(10);
        check("simul_level", 32'(key_level), 32'b111);
        btn = 3'b000;
        step(12);
        check("simul_release_level", 32'(key_level), 32'd0);

        // Auto-repeat on channel 1 held 50 cycles
        c = cyc;
        btn = 3'b010;
        push(2, 0, c + LAT);
        push(2, 1, c + LAT + 20);
        push(2, 1, c + LAT + 28);
        push(2, 1, c + LAT + 36);
        push(2, 1, c + LAT + 44);
        step(50);
        check("repeat_hold_level", 32'(key_level), 32'b010);
        btn = 3'b000;
        step(8);
        check("repeat_release_level", 32'(key_level), 32'd0);
        step(30);

        // Reset pulse while channel 0 is held
        c = cyc;
        btn = 3'b001;
        push(1, 0, c + LAT);
        step(12);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("midhold_rst_level", 32'(key_level), 32'd0);
        c = cyc;
        push(1, 0, c + LAT);
        step(15);
        check("midhold_level", 32'(key_level), 32'b001);
        btn = 3'b000;
        step(30);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
